// File: rtl/pixel_stream_fifo.sv
// Pixel FIFO between the frame-memory read port and the VGA output path.
// Registered 1-cycle read, background substitution, level flags, refill hint.
module pixel_stream_fifo #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       DEPTH    = 16,
  parameter int unsigned       LOW_WM   = 4,
  parameter logic [DATA_W-1:0] BG_COLOR = 16'h0000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Flush,
  input  logic                       MIMO_in_enable,
  input  logic [DATA_W-1:0]          Wr_data,
  input  logic                       MIMO_out_enable,
  input  logic                       Is_background,
  output logic [DATA_W-1:0]          Pixel_out,
  output logic                       Pixel_valid,
  output logic                       Full,
  output logic                       Empty,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Fetch_req,
  output logic                       Underflow,
  input  logic                       Clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] LOW_CNT  = (AW+1)'(LOW_WM);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_req;
  logic              pop_ok;
  logic              wr_ok;
  logic              uf_ev;

  // A full FIFO still takes a write when the same cycle pops a word.
  assign rd_req = MIMO_out_enable & ~Is_background;
  assign pop_ok = rd_req & ~Empty & ~Flush;
  assign uf_ev  = rd_req & Empty & ~Flush;
  assign wr_ok  = MIMO_in_enable & (~Full | pop_ok) & ~Flush;

  assign Full      = (Count == FULL_CNT);
  assign Empty     = (Count == '0);
  assign Fetch_req = (Count <= LOW_CNT) & ~Flush;

  // Storage write; contents need no reset.
  always_ff @(posedge Clk) begin
    if (wr_ok)
      mem[wr_ptr] <= Wr_data;
  end

  // Pointers and occupancy; flush restarts the frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop_ok})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  // Registered pixel path: head word on a pop, background otherwise.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Pixel_out   <= '0;
      Pixel_valid <= 1'b0;
    end else if (Flush) begin
      Pixel_valid <= 1'b0;
    end else if (MIMO_out_enable) begin
      Pixel_valid <= pop_ok;
      Pixel_out   <= pop_ok ? mem[rd_ptr] : BG_COLOR;
    end else begin
      Pixel_valid <= 1'b0;
    end
  end

  // Sticky underflow; a new underflow beats a clear in the same cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      Underflow <= 1'b0;
    else if (uf_ev)
      Underflow <= 1'b1;
    else if (Clr_err)
      Underflow <= 1'b0;
  end

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Bench for pixel_stream_fifo: directed vector table, async reset check,
// then random traffic against a queue-based reference model.
module tb_pixel_stream_fifo;

  localparam int DEPTH = 16;
  localparam int LOWWM = 4;
  localparam logic [15:0] BG = 16'h0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Flush;
  logic        MIMO_in_enable;
  logic [15:0] Wr_data;
  logic        MIMO_out_enable;
  logic        Is_background;
  logic [15:0] Pixel_out;
  logic        Pixel_valid;
  logic        Full;
  logic        Empty;
  logic [4:0]  Count;
  logic        Fetch_req;
  logic        Underflow;
  logic        Clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        flush;
    logic        in_en;
    logic [15:0] wd;
    logic        out_en;
    logic        bg;
    logic        clr;
    logic [4:0]  cnt;
    logic [15:0] pix;
    logic        valid;
    logic        uf;
  } vec_t;

  vec_t vecs[$];

  pixel_stream_fifo #(
    .DATA_W(16), .DEPTH(DEPTH), .LOW_WM(LOWWM), .BG_COLOR(BG)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Flush(Flush),
    .MIMO_in_enable(MIMO_in_enable),
    .Wr_data(Wr_data),
    .MIMO_out_enable(MIMO_out_enable),
    .Is_background(Is_background),
    .Pixel_out(Pixel_out),
    .Pixel_valid(Pixel_valid),
    .Full(Full),
    .Empty(Empty),
    .Count(Count),
    .Fetch_req(Fetch_req),
    .Underflow(Underflow),
    .Clr_err(Clr_err)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(logic f, logic i, logic [15:0] w,
                              logic o, logic b, logic c,
                              logic [4:0] n, logic [15:0] p,
                              logic v, logic u);
    vec_t r;
    r.flush = f; r.in_en = i; r.wd = w;
    r.out_en = o; r.bg = b; r.clr = c;
    r.cnt = n; r.pix = p; r.valid = v; r.uf = u;
    return r;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all(int n, logic [15:0] p, logic v,
                           logic u, logic f);
    chk("count", 16'(Count), 16'(n));
    chk("full", 16'(Full), 16'(n == DEPTH));
    chk("empty", 16'(Empty), 16'(n == 0));
    chk("fetch_req", 16'(Fetch_req), 16'((n <= LOWWM) && !f));
    chk("pixel_out", Pixel_out, p);
    chk("pixel_valid", 16'(Pixel_valid), 16'(v));
    chk("underflow", 16'(Underflow), 16'(u));
  endtask

  task automatic drive(logic f, logic i, logic [15:0] w,
                       logic o, logic b, logic c);
    Flush = f; MIMO_in_enable = i; Wr_data = w;
    MIMO_out_enable = o; Is_background = b; Clr_err = c;
  endtask

  logic [15:0] q[$];
  logic [15:0] m_pix;
  logic        m_valid;
  logic        m_uf;

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // fill 0001..0010; drop when full; push+pop when full
    for (int i = 1; i <= 16; i++)
      vecs.push_back(mk(0, 1, 16'(i), 0, 0, 0, 5'(i), 16'h0, 0, 0));
    vecs.push_back(mk(0, 1, 16'hBEEF, 0, 0, 0, 16, 16'h0, 0, 0));
    vecs.push_back(mk(0, 1, 16'hAAAA, 1, 0, 0, 16, 16'h0001, 1, 0));
    // drain: 0002..0010 then AAAA
    for (int i = 2; i <= 16; i++)
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'(17 - i), 16'(i), 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 16'hAAAA, 1, 0));
    // underflow, hold, clear-vs-set, clear
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, BG, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, BG, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, BG, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, BG, 0, 0));
    // count 4, pop one to 3, then 5 background reads
    vecs.push_back(mk(0, 1, 16'h0011, 0, 0, 0, 1, BG, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0022, 0, 0, 0, 2, BG, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0033, 0, 0, 0, 3, BG, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0044, 0, 0, 0, 4, BG, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 16'h0011, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 3, BG, 0, 0));
    // grow to 7, flush with push+pop, fetch returns next cycle
    for (int i = 4; i <= 7; i++)
      vecs.push_back(mk(0, 1, 16'(i * 16'h0101), 0, 0, 0, 5'(i), BG, 0, 0));
    vecs.push_back(mk(1, 1, 16'h9999, 1, 0, 0, 0, BG, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, BG, 0, 0));
    // empty push+pop: push lands, read underflows, word comes later
    vecs.push_back(mk(0, 1, 16'h0123, 1, 0, 0, 1, BG, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 16'h0123, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0123, 0, 0));

    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check_all(0, 16'h0, 0, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].flush, vecs[k].in_en, vecs[k].wd,
            vecs[k].out_en, vecs[k].bg, vecs[k].clr);
      @(posedge Clk);
      #1;
      check_all(vecs[k].cnt, vecs[k].pix, vecs[k].valid,
                vecs[k].uf, vecs[k].flush);
    end

    // async reset between edges while data and errors are live
    drive(0, 0, 0, 1, 0, 0);
    @(posedge Clk); #1;
    drive(0, 1, 16'h5A5A, 0, 0, 0);
    @(posedge Clk); #1;
    drive(0, 1, 16'h1234, 0, 0, 0);
    @(posedge Clk); #1;
    drive(0, 1, 16'h7777, 1, 0, 0);
    @(posedge Clk); #1;
    check_all(2, 16'h5A5A, 1, 1, 0);
    #2;
    Reset = 1'b1;
    #1;
    check_all(0, 16'h0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // random traffic against the queue model
    q.delete();
    m_pix = '0;
    m_valid = 1'b0;
    m_uf = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      logic f, i, o, b, c, pop, push;
      logic [15:0] w;
      f = ($urandom_range(0, 31) == 0);
      i = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 55);
      b = ($urandom_range(0, 99) < 20);
      c = ($urandom_range(0, 9) == 0);
      w = 16'($urandom);
      if (f) begin
        q.delete();
        m_valid = 1'b0;
        if (c) m_uf = 1'b0;
      end else begin
        pop  = o && !b && (q.size() > 0);
        push = i && ((q.size() < DEPTH) || pop);
        if (o) begin
          m_pix   = pop ? q.pop_front() : BG;
          m_valid = pop;
        end else begin
          m_valid = 1'b0;
        end
        if (o && !b && !pop) m_uf = 1'b1;
        else if (c)          m_uf = 1'b0;
        if (push) q.push_back(w);
      end
      drive(f, i, w, o, b, c);
      @(posedge Clk);
      #1;
      check_all(q.size(), m_pix, m_valid, m_uf, f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
